blink_rate_decoder: RTL and testbench

Receive-side companion to the programmable rear-light blinker. It watches a blinking light signal, measures the interval between toggles in timebase ticks, and decodes it back to the one-hot 4-bit rate code the blinker was programmed with. It reports a per-interval valid strobe, a lock indication and a loss-of-signal timeout. It sits in the monitor/self-test path, driven from the blinker's light output or an external pin.

---
 rtl/blink_rate_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_blink_rate_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_decoder.sv
// blink_rate_decoder
// Measures the tick interval between toggles of an observed light signal and
// decodes it back to the one-hot rate code of the blinker that produced it.
// Reports a per-interval valid strobe, a lock flag after two matching
// intervals, and a one-shot loss-of-signal timeout.
module blink_rate_decoder #(
    parameter int BASE  = 4,
    parameter int TOL   = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       light_in,
    input  logic       tick_en,
    output logic [3:0] rate_code,
    output logic       valid,
    output logic       locked,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Longest legal interval plus tolerance plus one: reaching it means the
    // light has stopped toggling.
    localparam logic [CNT_W-1:0] TMO     = CNT_W'((BASE << 3) + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W + 1)'(TOL);

    // Synchronizer and edge history
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic edge_det;

    // Interval counter
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   interval_ext;

    // Classifier
    logic [3:0] match;
    logic [3:0] cls_code;

    // Decoder state and registered outputs
    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [3:0] rate_code_q, rate_code_d;
    logic       valid_q, valid_d;
    logic       locked_q, locked_d;
    logic       timeout_q, timeout_d;

    // Synchronizer next values; prev lags sync2 by one cycle so that any
    // transition of the synchronized light shows up as a one-cycle edge.
    always_comb begin
        sync1_d = light_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign edge_det = sync2_q ^ prev_q;

    // Synchronizer and edge-history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Interval counter: restarts on every edge (counting the edge cycle's own
    // tick if present), otherwise counts ticks and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_det) begin
            cnt_d = tick_en ? CNT_W'(1) : '0;
        end else if (tick_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Interval counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One extra bit of headroom so the distance to each nominal interval is
    // computed without wraparound in either direction.
    assign interval_ext = {1'b0, cnt_q};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_match
            localparam logic [CNT_W:0] NOM = (CNT_W + 1)'(BASE << gi);
            assign match[gi] = (interval_ext >= NOM) ? ((interval_ext - NOM) <= TOL_X)
                                                     : ((NOM - interval_ext) <= TOL_X);
        end
    endgenerate

    // Lowest matching rate wins; no match decodes as the unknown code.
    always_comb begin
        cls_code = 4'b0000;
        if (match[0]) begin
            cls_code = 4'b0001;
        end else if (match[1]) begin
            cls_code = 4'b0010;
        end else if (match[2]) begin
            cls_code = 4'b0100;
        end else if (match[3]) begin
            cls_code = 4'b1000;
        end
    end

    // Decoder FSM next state and outputs. An edge always takes precedence over
    // the timeout, so a toggle landing exactly at the limit is still classified.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        rate_code_d = rate_code_q;
        locked_d    = locked_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // First edge only establishes the reference point.
                if (edge_det) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_det) begin
                    valid_d     = 1'b1;
                    rate_code_d = cls_code;
                    code_d      = cls_code;
                    if ((cls_code != 4'b0000) && (cls_code == code_q)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        locked_d = 1'b0;
                    end
                end else if (cnt_q >= TMO) begin
                    state_d     = ST_IDLE;
                    timeout_d   = 1'b1;
                    rate_code_d = 4'b0000;
                    code_d      = 4'b0000;
                    locked_d    = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (edge_det) begin
                    valid_d     = 1'b1;
                    rate_code_d = cls_code;
                    code_d      = cls_code;
                    if ((cls_code == 4'b0000) || (cls_code != code_q)) begin
                        state_d  = ST_MEASURE;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q >= TMO) begin
                    state_d     = ST_IDLE;
                    timeout_d   = 1'b1;
                    rate_code_d = 4'b0000;
                    code_d      = 4'b0000;
                    locked_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoder state and registered output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            code_q      <= 4'b0000;
            rate_code_q <= 4'b0000;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            rate_code_q <= rate_code_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign rate_code = rate_code_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed testbench for blink_rate_decoder. Each task drives one scenario
// and checks the outputs against hand-computed expectations.
module tb_blink_rate_decoder;

    logic       clk;
    logic       rst;
    logic       light_in;
    logic       tick_en;
    logic [3:0] rate_code;
    logic       valid;
    logic       locked;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Results collected over one hold window
    logic [3:0] vc;
    logic [3:0] v_code;
    logic       v_lock;
    logic [3:0] tc;
    int         t_at;
    logic [3:0] t_code;
    logic       t_lock;
    bit         tick_mode;

    blink_rate_decoder #(
        .BASE (4),
        .TOL  (1),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .light_in (light_in),
        .tick_en  (tick_en),
        .rate_code(rate_code),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optionally toggle light_in, then hold for n cycles collecting any valid
    // and timeout pulses. A valid seen here reports the interval that this
    // toggle closed (i.e. the hold length of the previous call).
    task automatic run(input bit do_toggle, input int n);
        if (do_toggle) light_in = ~light_in;
        vc = 0; v_code = 4'b0000; v_lock = 1'b0;
        tc = 0; t_at = 0; t_code = 4'b0000; t_lock = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                vc = vc + 1; v_code = rate_code; v_lock = locked;
            end
            if (timeout) begin
                tc = tc + 1; t_at = i; t_code = rate_code; t_lock = locked;
            end
            if (tick_mode) tick_en = ~tick_en;
        end
        $display("hold toggle=%0d n=%0d valids=%0d code=%b locked=%b timeouts=%0d at=%0d",
                 do_toggle, n, vc, v_code, v_lock, tc, t_at);
    endtask

    task automatic apply_reset();
        rst = 1'b0; light_in = 1'b0; tick_en = 1'b1; tick_mode = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; light_in = 1'b0; tick_en = 1'b1; tick_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            light_in = ~light_in;
            tick();
            checks++;
            if ({rate_code, valid, locked, timeout} !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d got code/v/l/t=%b/%b/%b/%b exp all 0",
                         i, rate_code, valid, locked, timeout);
            end
        end
        light_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        run(1, 8);
        checks++;
        if (vc !== 4'd0) begin
            errors++; $display("FAIL reset_edge1 got valids=%0d exp 0", vc);
        end
        run(1, 8);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL reset_edge2 got valids/code/lock=%0d/%b/%b exp 1/0010/0", vc, v_code, v_lock);
        end
    endtask

    task automatic test_rate_0010();
        apply_reset();
        run(1, 8);
        checks++;
        if (vc !== 4'd0) begin
            errors++; $display("FAIL r0010_edge1 got valids=%0d exp 0", vc);
        end
        run(1, 8);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL r0010_edge2 got valids/code/lock=%0d/%b/%b exp 1/0010/0", vc, v_code, v_lock);
        end
        for (int e = 3; e <= 5; e++) begin
            run(1, 8);
            checks++;
            if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b1}) begin
                errors++;
                $display("FAIL r0010_edge%0d got valids/code/lock=%0d/%b/%b exp 1/0010/1", e, vc, v_code, v_lock);
            end
        end
    endtask

    task automatic test_rate_1000_tol();
        apply_reset();
        run(1, 32);
        run(1, 33);   // closes 32
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b1000, 1'b0}) begin
            errors++;
            $display("FAIL r1000_int32 got valids/code/lock=%0d/%b/%b exp 1/1000/0", vc, v_code, v_lock);
        end
        run(1, 31);   // closes 33
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL r1000_int33 got valids/code/lock=%0d/%b/%b exp 1/1000/1", vc, v_code, v_lock);
        end
        run(1, 8);    // closes 31
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL r1000_int31 got valids/code/lock=%0d/%b/%b exp 1/1000/1", vc, v_code, v_lock);
        end
    endtask

    task automatic test_mismatch();
        apply_reset();
        run(1, 8);
        run(1, 8);
        run(1, 8);
        run(1, 6);    // closes 8, still locked
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL mis_locked got valids/code/lock=%0d/%b/%b exp 1/0010/1", vc, v_code, v_lock);
        end
        run(1, 8);    // closes 6
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL mis_int6 got valids/code/lock=%0d/%b/%b exp 1/0000/0", vc, v_code, v_lock);
        end
        run(1, 8);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL mis_recover1 got valids/code/lock=%0d/%b/%b exp 1/0010/0", vc, v_code, v_lock);
        end
        run(1, 8);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL mis_recover2 got valids/code/lock=%0d/%b/%b exp 1/0010/1", vc, v_code, v_lock);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        run(1, 4);
        run(1, 4);
        run(1, 4);
        run(1, 4);    // last toggle; closes 4
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL tmo_locked got valids/code/lock=%0d/%b/%b exp 1/0001/1", vc, v_code, v_lock);
        end
        // Counter hits 34 in cycle 36 after the toggle; pulse seen at 37,
        // which is cycle 33 of this quiet window.
        run(0, 80);
        checks++;
        if ({tc, vc} !== {4'd1, 4'd0}) begin
            errors++; $display("FAIL tmo_count got timeouts/valids=%0d/%0d exp 1/0", tc, vc);
        end
        checks++;
        if (t_at !== 33) begin
            errors++; $display("FAIL tmo_cycle got %0d exp 33", t_at);
        end
        checks++;
        if ({t_code, t_lock} !== {4'b0000, 1'b0}) begin
            errors++; $display("FAIL tmo_outputs got code/lock=%b/%b exp 0000/0", t_code, t_lock);
        end
    endtask

    task automatic test_edge_vs_timeout();
        apply_reset();
        run(1, 4);
        run(1, 4);
        run(1, 4);
        run(1, 34);   // closes 4; the edge below lands on the timeout cycle
        checks++;
        if ({vc, v_code, v_lock, tc} !== {4'd1, 4'b0001, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL evt_pre got valids/code/lock/tmo=%0d/%b/%b/%0d exp 1/0001/1/0", vc, v_code, v_lock, tc);
        end
        run(1, 40);   // closes 34 -> unknown, then times out from MEASURE
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL evt_int34 got valids/code/lock=%0d/%b/%b exp 1/0000/0", vc, v_code, v_lock);
        end
        checks++;
        if ({tc, 8'(t_at)} !== {4'd1, 8'd37}) begin
            errors++; $display("FAIL evt_tmo got timeouts/at=%0d/%0d exp 1/37", tc, t_at);
        end
    endtask

    task automatic test_tick_en();
        apply_reset();
        tick_mode = 1'b1;
        run(1, 32);
        run(1, 32);   // 16 ticks in 32 cycles
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL tick_edge2 got valids/code/lock=%0d/%b/%b exp 1/0100/0", vc, v_code, v_lock);
        end
        run(1, 32);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL tick_edge3 got valids/code/lock=%0d/%b/%b exp 1/0100/1", vc, v_code, v_lock);
        end
        tick_mode = 1'b0;
        tick_en = 1'b1;
    endtask

    task automatic test_async_reset();
        apply_reset();
        run(1, 8);
        run(1, 8);
        run(1, 8);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL ares_locked got valids/code/lock=%0d/%b/%b exp 1/0010/1", vc, v_code, v_lock);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rate_code, locked} !== {4'b0000, 1'b0}) begin
            errors++; $display("FAIL ares_immediate got code/lock=%b/%b exp 0000/0", rate_code, locked);
        end
        light_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        run(1, 16);
        checks++;
        if (vc !== 4'd0) begin
            errors++; $display("FAIL ares_edge1 got valids=%0d exp 0", vc);
        end
        run(1, 16);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL ares_edge2 got valids/code/lock=%0d/%b/%b exp 1/0100/0", vc, v_code, v_lock);
        end
        run(1, 16);
        checks++;
        if ({vc, v_code, v_lock} !== {4'd1, 4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL ares_edge3 got valids/code/lock=%0d/%b/%b exp 1/0100/1", vc, v_code, v_lock);
        end
    endtask

    initial begin
        rst = 1'b0;
        light_in = 1'b0;
        tick_en = 1'b1;
        tick_mode = 1'b0;
        test_reset();
        test_rate_0010();
        test_rate_1000_tol();
        test_mismatch();
        test_timeout();
        test_edge_vs_timeout();
        test_tick_en();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
